// File: rtl/shift_issue_stage.sv
// Issue stage feeding the barrel shifter: decodes R-type shift functs into
// mode/shamt, buffers ops in a 2-entry skid buffer, and keeps debug counters.
module shift_issue_stage #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [4:0]         instr_shamt,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    input  logic [4:0]         rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        sh_a,
    output logic [4:0]         sh_shamt,
    output logic [1:0]         sh_mode,
    output logic [4:0]         out_rd,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] issued_count,
    output logic [COUNT_W-1:0] illegal_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  mode;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    function automatic entry_t decode(input logic [5:0]  f,
                                      input logic [4:0]  ishamt,
                                      input logic [4:0]  vshamt,
                                      input logic [31:0] rt,
                                      input logic [4:0]  tag);
        entry_t e;
        e.a       = rt;
        e.rd      = tag;
        e.illegal = 1'b0;
        case (f)
            6'h00:   begin e.mode = 2'b00; e.shamt = ishamt; end
            6'h02:   begin e.mode = 2'b01; e.shamt = ishamt; end
            6'h03:   begin e.mode = 2'b10; e.shamt = ishamt; end
            6'h04:   begin e.mode = 2'b00; e.shamt = vshamt; end
            6'h06:   begin e.mode = 2'b01; e.shamt = vshamt; end
            6'h07:   begin e.mode = 2'b10; e.shamt = vshamt; end
            // Mode 11 makes the shifter output zero for non-shift ops.
            default: begin e.mode = 2'b11; e.shamt = 5'd0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    entry_t             r_main;
    entry_t             r_skid;
    entry_t             w_dec;
    logic [COUNT_W-1:0] r_issued_count;
    logic [COUNT_W-1:0] r_illegal_count;
    logic               w_accept;
    logic               w_pop;
    logic               w_main_from_in;
    logic               w_main_from_skid;
    logic               w_skid_from_in;
    logic               w_unused_rs;

    assign w_unused_rs = ^rs_val[31:5];

    // in_ready depends only on registered state so it never combinationally follows out_ready.
    assign in_ready  = (r_state != TWO) && !reset;
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_dec     = decode(funct, instr_shamt, rs_val[4:0], rt_val, rd);

    always_comb begin
        w_state_next     = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ONE;
                    w_main_from_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_main_from_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next   = TWO;
                    w_skid_from_in = 1'b1;
                end else if (w_pop) begin
                    w_state_next   = EMPTY;
                end
            end
            TWO: begin
                if (w_pop) begin
                    w_state_next     = ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= EMPTY;
            r_main          <= '0;
            r_skid          <= '0;
            r_issued_count  <= '0;
            r_illegal_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_main_from_in) begin
                r_main <= w_dec;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= w_dec;
            end
            if (w_pop) begin
                r_issued_count <= r_issued_count + COUNT_W'(1);
            end
            if (w_accept && w_dec.illegal && (r_illegal_count != '1)) begin
                r_illegal_count <= r_illegal_count + COUNT_W'(1);
            end
        end
    end

    assign sh_a          = r_main.a;
    assign sh_shamt      = r_main.shamt;
    assign sh_mode       = r_main.mode;
    assign out_rd        = r_main.rd;
    assign out_illegal   = r_main.illegal;
    assign issued_count  = r_issued_count;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scenario bench for shift_issue_stage: a negedge monitor scoreboards every
// accepted op against every popped op; tasks check control and counters inline.
module tb_shift_issue_stage;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    funct = '0;
    logic [4:0]    instr_shamt = '0;
    logic [31:0]   rs_val = '0;
    logic [31:0]   rt_val = '0;
    logic [4:0]    rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   sh_a;
    logic [4:0]    sh_shamt;
    logic [1:0]    sh_mode;
    logic [4:0]    out_rd;
    logic          out_illegal;
    logic [CW-1:0] issued_count;
    logic [CW-1:0] illegal_count;

    shift_issue_stage #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .instr_shamt(instr_shamt), .rs_val(rs_val), .rt_val(rt_val),
        .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .sh_a(sh_a),
        .sh_shamt(sh_shamt), .sh_mode(sh_mode), .out_rd(out_rd),
        .out_illegal(out_illegal), .issued_count(issued_count),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  mode;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_issued = 0;
    int   m_illegal = 0;
    int   pops = 0;

    function automatic exp_t model(input logic [5:0] f, input logic [4:0] is,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] d);
        exp_t e;
        e.a = rt;
        e.rd = d;
        e.ill = 1'b0;
        if (f == 6'h00 || f == 6'h02 || f == 6'h03)
            e.shamt = is;
        else if (f == 6'h04 || f == 6'h06 || f == 6'h07)
            e.shamt = rs[4:0];
        else begin
            e.shamt = 5'd0;
            e.ill = 1'b1;
        end
        if (e.ill) e.mode = 2'b11;
        else if (f[1:0] == 2'b00) e.mode = 2'b00;
        else if (f[1:0] == 2'b10) e.mode = 2'b01;
        else e.mode = 2'b10;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (reset) begin
            sb.delete();
            m_issued = 0;
            m_illegal = 0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                got = {sh_a, sh_shamt, sh_mode, out_rd, out_illegal};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got %h required no pop", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL pop_data got %h required %h", got, e);
                    end
                end
                m_issued = (m_issued + 1) % (1 << CW);
                pops++;
            end
            if (in_valid && in_ready) begin
                e = model(funct, instr_shamt, rs_val, rt_val, rd);
                sb.push_back(e);
                if (e.ill && m_illegal < (1 << CW) - 1) m_illegal++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] f, input logic [4:0] is,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic [4:0] d);
        in_valid = 1'b1;
        funct = f;
        instr_shamt = is;
        rs_val = rs;
        rt_val = rt;
        rd = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++;
        if ({sh_a, sh_shamt, sh_mode, out_rd, out_illegal} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h required 0", {sh_a, sh_shamt, sh_mode, out_rd, out_illegal});
        end
        checks++;
        if ({issued_count, illegal_count} !== '0) begin
            errors++; $display("FAIL reset_counters got %h required 0", {issued_count, illegal_count});
        end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_sra();
        out_ready = 1'b1;
        drive_op(6'h03, 5'd4, 32'h0, 32'h8000_0000, 5'd5);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sra_out_valid got %b required 1", out_valid); end
        checks++; if (sh_a !== 32'h8000_0000) begin errors++; $display("FAIL sra_a got %h required 80000000", sh_a); end
        checks++; if (sh_shamt !== 5'd4) begin errors++; $display("FAIL sra_shamt got %0d required 4", sh_shamt); end
        checks++; if (sh_mode !== 2'b10) begin errors++; $display("FAIL sra_mode got %b required 10", sh_mode); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL sra_illegal got %b required 0", out_illegal); end
        tick();
        checks++; if (issued_count !== 8'd1) begin errors++; $display("FAIL sra_issued got %0d required 1", issued_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sra_drained got %b required 0", out_valid); end
    endtask

    task automatic test_srav_mask();
        out_ready = 1'b0;
        drive_op(6'h07, 5'd9, 32'h0000_0024, 32'hF000_0000, 5'd9);
        tick();
        in_valid = 1'b0;
        checks++; if (sh_shamt !== 5'd4) begin errors++; $display("FAIL srav_shamt got %0d required 4", sh_shamt); end
        checks++; if (sh_mode !== 2'b10) begin errors++; $display("FAIL srav_mode got %b required 10", sh_mode); end
        checks++; if (sh_a !== 32'hF000_0000) begin errors++; $display("FAIL srav_a got %h required F0000000", sh_a); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive_op(6'h00, 5'd7, 32'h0, 32'h0000_00F1, 5'd1);
                1: drive_op(6'h06, 5'd0, 32'hFFFF_FFE3, 32'h1234_5678, 5'd2);
                default: drive_op(6'h02, 5'd31, 32'h0, 32'hDEAD_BEEF, 5'd3);
            endcase
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b required 1 (op %0d)", in_ready, i); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b required 1 (op %0d)", out_valid, i); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (pops - p0 !== 3) begin errors++; $display("FAIL b2b_pop_count got %0d required 3", pops - p0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_op(6'h04, 5'd0, 32'h3, 32'hAAAA_0001, 5'd10);
        tick();
        drive_op(6'h03, 5'd1, 32'h0, 32'hBBBB_0002, 5'd11);
        tick();
        drive_op(6'h07, 5'd0, 32'h1F, 32'hCCCC_0003, 5'd12);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b required 0", in_ready); end
        checks++; if (sh_a !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_head got %h required AAAA0001", sh_a); end
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready got %b required 0", in_ready); end
        checks++; if (sh_a !== 32'hAAAA_0001 || out_rd !== 5'd10) begin errors++; $display("FAIL bp_hold_head got %h/%0d required AAAA0001/10", sh_a, out_rd); end
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b required 1", in_ready); end
        checks++; if (sh_a !== 32'hBBBB_0002) begin errors++; $display("FAIL bp_second got %h required BBBB0002", sh_a); end
        tick();
        in_valid = 1'b0;
        checks++; if (sh_a !== 32'hCCCC_0003) begin errors++; $display("FAIL bp_third got %h required CCCC0003", sh_a); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b required 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive_op(6'h20, 5'd17, 32'h1F, 32'h5555_AAAA, 5'd20);
        tick();
        in_valid = 1'b0;
        checks++; if (sh_mode !== 2'b11) begin errors++; $display("FAIL ill_mode got %b required 11", sh_mode); end
        checks++; if (sh_shamt !== 5'd0) begin errors++; $display("FAIL ill_shamt got %0d required 0", sh_shamt); end
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b required 1", out_illegal); end
        checks++; if (sh_a !== 32'h5555_AAAA) begin errors++; $display("FAIL ill_a got %h required 5555AAAA", sh_a); end
        checks++; if (illegal_count !== CW'(m_illegal)) begin errors++; $display("FAIL ill_count got %0d required %0d", illegal_count, m_illegal); end
        for (int i = 0; i < 300; i++) begin
            drive_op(6'(8 + $urandom_range(0, 55)), 5'($urandom), $urandom, $urandom, 5'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (illegal_count !== 8'd255) begin errors++; $display("FAIL ill_saturate got %0d required 255", illegal_count); end
        checks++; if (issued_count !== CW'(m_issued)) begin errors++; $display("FAIL issued_wrap got %0d required %0d", issued_count, m_issued); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_op(6'h00, 5'd3, 32'h0, 32'h0000_0011, 5'd1);
        tick();
        drive_op(6'h21, 5'd3, 32'h0, 32'h0000_0022, 5'd2);
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got ready %b valid %b required 0 1", in_ready, out_valid); end
        drive_op(6'h02, 5'd1, 32'h0, 32'h0000_0033, 5'd3);
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got %b required 0", in_ready); end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b required 0", out_valid); end
        checks++;
        if ({sh_a, sh_shamt, sh_mode, out_rd, out_illegal} !== '0) begin
            errors++; $display("FAIL mid_outputs got %h required 0", {sh_a, sh_shamt, sh_mode, out_rd, out_illegal});
        end
        checks++;
        if ({issued_count, illegal_count} !== '0) begin
            errors++; $display("FAIL mid_counters got %h required 0", {issued_count, illegal_count});
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b required 1", in_ready); end
        out_ready = 1'b1;
        drive_op(6'h02, 5'd3, 32'h0, 32'h8000_0010, 5'd7);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || sh_mode !== 2'b01 || sh_shamt !== 5'd3) begin
            errors++; $display("FAIL mid_next_op got valid %b mode %b shamt %0d required 1 01 3", out_valid, sh_mode, sh_shamt);
        end
        tick();
        checks++; if (issued_count !== 8'd1) begin errors++; $display("FAIL mid_next_issued got %0d required 1", issued_count); end
    endtask

    initial begin
        test_reset();
        test_sra();
        test_srav_mask();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d required 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
